ssc_seq: RTL and testbench

SSC_SEQ -- requirements
Module: ssc_seq

---
 rtl/ssc_seq.sv | 138 +++++++++++++
 tb/tb_ssc_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ssc_seq.sv
// Snack-shop checkout sequencer: loads 8 beats of card/snack data, sorts item
// costs on the fly, pays largest-first until an item does not fit, then reports.
module ssc_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_card,
  input  logic [3:0] in_snack,
  input  logic [3:0] in_price,
  input  logic [8:0] in_money,
  output logic       out_valid,
  output logic       out_card_ok,
  output logic [8:0] out_change
);

  typedef enum logic [1:0] {IDLE, LOAD, PAY, OUT} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0][7:0] sortBuf_q, sortBuf_d;
  logic [6:0]      checksum_q, checksum_d;
  logic [8:0]      money_q, money_d;
  logic [8:0]      remain_q, remain_d;
  logic            stop_q, stop_d;

  logic [7:0]      product;
  logic [3:0]      highDigit;
  logic [4:0]      highMapped;
  logic [6:0]      beatSum;
  logic [7:0][7:0] insBase;
  logic [7:0][7:0] inserted;
  logic [7:0]      payEntry;
  logic            cardOk;

  assign product    = {4'b0, in_snack} * {4'b0, in_price};
  assign highDigit  = in_card[7:4];
  assign highMapped = (highDigit <= 4'd4) ? {highDigit, 1'b0} : ({highDigit, 1'b0} - 5'd9);
  assign beatSum    = {3'b0, in_card[3:0]} + {2'b0, highMapped};
  assign payEntry   = sortBuf_q[cnt_q];
  assign cardOk     = ((checksum_q % 7'd10) == 7'd0);

  // Sorted insert: empty slots hold 0, so a fresh beat 0 inserts into an all-zero buffer.
  always_comb begin
    insBase  = (state_q == IDLE) ? '0 : sortBuf_q;
    inserted = insBase;
    inserted[0] = (insBase[0] >= product) ? insBase[0] : product;
    for (int j = 1; j < 8; j++) begin
      if (insBase[j] >= product)
        inserted[j] = insBase[j];
      else if (insBase[j-1] >= product)
        inserted[j] = product;
      else
        inserted[j] = insBase[j-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sortBuf_d   = sortBuf_q;
    checksum_d  = checksum_q;
    money_d     = money_q;
    remain_d    = remain_q;
    stop_d      = stop_q;
    out_valid   = 1'b0;
    out_card_ok = 1'b0;
    out_change  = 9'd0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sortBuf_d  = inserted;
          checksum_d = beatSum;
          money_d    = in_money;
          remain_d   = in_money;
          stop_d     = 1'b0;
          cnt_d      = 3'd1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (!in_valid) begin
          cnt_d   = 3'd0;
          state_d = IDLE;
        end else begin
          sortBuf_d  = inserted;
          checksum_d = checksum_q + beatSum;
          if (cnt_q == 3'd7) begin
            cnt_d   = 3'd0;
            state_d = PAY;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      PAY: begin
        // Once one item fails to fit, later (smaller) items are never bought.
        if (!stop_q) begin
          if ({1'b0, payEntry} <= remain_q)
            remain_d = remain_q - {1'b0, payEntry};
          else
            stop_d = 1'b1;
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7)
          state_d = OUT;
      end
      OUT: begin
        out_valid   = 1'b1;
        out_card_ok = cardOk;
        out_change  = cardOk ? remain_q : money_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      sortBuf_q  <= '0;
      checksum_q <= 7'd0;
      money_q    <= 9'd0;
      remain_q   <= 9'd0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sortBuf_q  <= sortBuf_d;
      checksum_q <= checksum_d;
      money_q    <= money_d;
      remain_q   <= remain_d;
      stop_q     <= stop_d;
    end
  end

endmodule

// File: tb/tb_ssc_seq.sv
// Self-checking bench for ssc_seq: directed table, abort/reset sequences and
// randomized transactions checked against a sort-and-greedy reference model.
module tb_ssc_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_card = '0;
  logic [3:0] in_snack = '0;
  logic [3:0] in_price = '0;
  logic [8:0] in_money = '0;
  logic       out_valid;
  logic       out_card_ok;
  logic [8:0] out_change;

  typedef struct packed {
    logic [63:0] card;
    logic [31:0] snack;
    logic [31:0] price;
    logic [8:0]  money;
    logic        expOk;
    logic [8:0]  expChange;
  } vec_t;

  int nVectors = 0;
  int nMiscompares = 0;

  always #5 clk = ~clk;

  ssc_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_card    (in_card),
    .in_snack   (in_snack),
    .in_price   (in_price),
    .in_money   (in_money),
    .out_valid  (out_valid),
    .out_card_ok(out_card_ok),
    .out_change (out_change)
  );

  task automatic checkOutput(input string name, input logic v, input logic ok, input logic [8:0] ch);
    nVectors++;
    if ({out_valid, out_card_ok, out_change} !== {v, ok, ch}) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got valid=%0b ok=%0b change=%0d, want valid=%0b ok=%0b change=%0d",
               name, out_valid, out_card_ok, out_change, v, ok, ch);
    end
  endtask

  // Reference: Luhn-style digit sum in a 7-bit accumulator, then buy largest-first until one misses.
  function automatic void model(input vec_t v, output logic ok, output logic [8:0] change);
    int sum = 0;
    int rem;
    int items[$];
    for (int k = 0; k < 8; k++) begin
      int lo = int'(v.card[8*k +: 4]);
      int hi = int'(v.card[8*k+4 +: 4]);
      sum += lo + ((hi <= 4) ? 2*hi : 2*hi - 9);
      items.push_back(int'(v.snack[4*k +: 4]) * int'(v.price[4*k +: 4]));
    end
    items.rsort();
    ok  = ((sum % 128) % 10) == 0;
    rem = int'(v.money);
    for (int i = 0; i < 8; i++) begin
      if (items[i] > rem) break;
      rem -= items[i];
    end
    change = ok ? 9'(rem) : v.money;
  endfunction

  task automatic driveBeat(input vec_t v, input int k);
    in_valid = 1'b1;
    in_card  = v.card[8*k +: 8];
    in_snack = v.snack[4*k +: 4];
    in_price = v.price[4*k +: 4];
    in_money = (k == 0) ? v.money : 9'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic idleCycles(input string name, input int n);
    in_valid = 1'b0;
    for (int c = 0; c < n; c++) begin
      checkOutput(name, 1'b0, 1'b0, 9'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input bit noise, input string name);
    for (int k = 0; k < 8; k++) driveBeat(v, k);
    for (int c = 1; c <= 9; c++) begin
      if (noise) begin
        in_valid = 1'($urandom);
        in_card  = 8'($urandom);
        in_snack = 4'($urandom);
        in_price = 4'($urandom);
        in_money = 9'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      if (c == 9)
        checkOutput({name, "_out"}, 1'b1, v.expOk, v.expChange);
      else
        checkOutput($sformatf("%s_wait%0d", name, c), 1'b0, 1'b0, 9'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  function automatic vec_t randomVec();
    vec_t r;
    int s = 0;
    int lo, hi;
    r.snack = $urandom;
    r.price = $urandom;
    r.money = 9'($urandom);
    if ($urandom_range(0, 1) == 0) begin
      r.card = {$urandom, $urandom};
    end else begin
      for (int k = 1; k < 8; k++) begin
        lo = $urandom_range(0, 7);
        hi = $urandom_range(0, 4);
        r.card[8*k +: 8] = {4'(hi), 4'(lo)};
        s += lo + 2*hi;
      end
      hi = $urandom_range(0, 4);
      s += 2*hi;
      lo = (10 - (s % 10)) % 10;
      r.card[7:0] = {4'(hi), 4'(lo)};
    end
    model(r, r.expOk, r.expChange);
    return r;
  endfunction

  vec_t vecs[6];

  initial begin
    vecs[0] = '{card: 64'h0, snack: 32'h11111111, price: 32'h87654321, money: 9'd100, expOk: 1'b1, expChange: 9'd64};
    vecs[1] = '{card: 64'h0, snack: 32'h11111111, price: 32'h87654321, money: 9'd20,  expOk: 1'b1, expChange: 9'd5};
    vecs[2] = '{card: 64'h01, snack: 32'h11111111, price: 32'h87654321, money: 9'd100, expOk: 1'b0, expChange: 9'd100};
    vecs[3] = '{card: 64'h18, snack: 32'hFFFFFFFF, price: 32'hFFFFFFFF, money: 9'd511, expOk: 1'b1, expChange: 9'd61};
    vecs[4] = '{card: 64'h0, snack: 32'h11111111, price: 32'h87654321, money: 9'd36,  expOk: 1'b1, expChange: 9'd0};
    vecs[5] = '{card: 64'h0, snack: 32'h11111111, price: 32'h87654321, money: 9'd35,  expOk: 1'b1, expChange: 9'd0};

    #12;
    checkOutput("reset_outputs", 1'b0, 1'b0, 9'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idleCycles("post_reset_idle", 2);

    for (int i = 0; i < 6; i++)
      applyStimulus(vecs[i], 1'b0, $sformatf("table%0d", i));

    // Abort after beat 3, then a full transaction must still be correct.
    for (int k = 0; k < 4; k++) driveBeat(vecs[0], k);
    idleCycles("abort_idle", 20);
    applyStimulus(vecs[0], 1'b0, "after_abort");

    // Reset in PAY cycle 4: nothing may come out, nothing may resume.
    for (int k = 0; k < 8; k++) driveBeat(vecs[1], k);
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("rst_pay", 1'b0, 1'b0, 9'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idleCycles("rst_pay_idle", 15);
    applyStimulus(vecs[0], 1'b0, "after_rst_pay");

    // Reset asserted while the result pulse is up must clear it immediately.
    for (int k = 0; k < 8; k++) driveBeat(vecs[3], k);
    in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
    end
    checkOutput("pre_rst_out", 1'b1, 1'b1, 9'd61);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out", 1'b0, 1'b0, 9'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idleCycles("rst_out_idle", 3);
    applyStimulus(vecs[3], 1'b0, "after_rst_out");

    // Back-to-back random transactions with noise on the inputs during PAY/OUT.
    for (int i = 0; i < 40; i++)
      applyStimulus(randomVec(), 1'b1, $sformatf("rand%0d", i));
    idleCycles("final_idle", 3);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
